// File: rtl/leaf_user_port_fifo.sv
// Elastic first-word-fall-through buffer between a user kernel output stream and leaf_interface.
// ack_out/vld_out decode registered state plus flush; every other output is a register.
module leaf_user_port_fifo #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned DEPTH_BITS   = 4
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    ack_in,
  output logic [DEPTH_BITS:0]     count,
  output logic [31:0]             xfer_cnt,
  output logic                    ovf_sticky
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned PTR_W = DEPTH_BITS + 1;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wp;
  logic [PTR_W-1:0]        rp;
  logic [PTR_W-1:0]        wp_nxt;
  logic [PTR_W-1:0]        rp_nxt;
  logic [PAYLOAD_BITS-1:0] head_nxt;
  logic                    rdy;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  assign empty   = (wp == rp);
  assign full    = (wp[DEPTH_BITS-1:0] == rp[DEPTH_BITS-1:0]) && (wp[DEPTH_BITS] != rp[DEPTH_BITS]);
  assign ack_out = rdy && !full && !flush;
  assign vld_out = !empty && !flush;
  assign push    = vld_in && ack_out;
  assign pop     = vld_out && ack_in;

  // Next pointers and the word that will sit at the head after this edge.
  always_comb begin
    wp_nxt   = wp;
    rp_nxt   = rp;
    head_nxt = dout;
    if (flush) begin
      wp_nxt = '0;
      rp_nxt = '0;
    end else begin
      if (push) wp_nxt = wp + PTR_W'(1);
      if (pop)  rp_nxt = rp + PTR_W'(1);
    end
    if (push && (wp == rp_nxt)) head_nxt = din;
    else                        head_nxt = mem[rp_nxt[DEPTH_BITS-1:0]];
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk_user) begin
    if (push) mem[wp[DEPTH_BITS-1:0]] <= din;
  end

  // rdy holds ack_out low until the first edge after reset release.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      wp         <= '0;
      rp         <= '0;
      rdy        <= 1'b0;
      count      <= '0;
      xfer_cnt   <= '0;
      ovf_sticky <= 1'b0;
      dout       <= '0;
    end else begin
      wp       <= wp_nxt;
      rp       <= rp_nxt;
      rdy      <= 1'b1;
      count    <= wp_nxt - rp_nxt;
      dout     <= head_nxt;
      xfer_cnt <= xfer_cnt + 32'(pop);
      if (flush)                  ovf_sticky <= 1'b0;
      else if (vld_in && !ack_out) ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_user_port_fifo.sv
// Directed self-checking bench for leaf_user_port_fifo (16-deep, 32-bit payload).
module tb_leaf_user_port_fifo;

  localparam int unsigned PW = 32;
  localparam int unsigned DB = 4;

  logic          clk_user = 1'b0;
  logic          reset_n  = 1'b0;
  logic          flush    = 1'b0;
  logic [PW-1:0] din      = '0;
  logic          vld_in   = 1'b0;
  logic          ack_in   = 1'b0;
  logic          ack_out;
  logic [PW-1:0] dout;
  logic          vld_out;
  logic [DB:0]   count;
  logic [31:0]   xfer_cnt;
  logic          ovf_sticky;

  int checks   = 0;
  int failures = 0;

  leaf_user_port_fifo #(.PAYLOAD_BITS(PW), .DEPTH_BITS(DB)) dut (
    .clk_user   (clk_user),
    .reset_n    (reset_n),
    .flush      (flush),
    .din        (din),
    .vld_in     (vld_in),
    .ack_out    (ack_out),
    .dout       (dout),
    .vld_out    (vld_out),
    .ack_in     (ack_in),
    .count      (count),
    .xfer_cnt   (xfer_cnt),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk_user = ~clk_user;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance one clock; returns on the falling edge so outputs are stable.
  task automatic tick();
    @(posedge clk_user);
    @(negedge clk_user);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    #1;
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack_out); end
    checks++; if (vld_out !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", vld_out); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (xfer_cnt !== 32'd0) begin failures++; $display("FAIL rst_xfer got=%0d exp=0", xfer_cnt); end
    checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", ovf_sticky); end
    reset_n = 1'b1;
    #1;
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL rel_ack_pre_edge got=%b exp=0", ack_out); end
    tick();
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL rel_ack_post_edge got=%b exp=1", ack_out); end
    checks++; if (vld_out !== 1'b0) begin failures++; $display("FAIL rel_vld got=%b exp=0", vld_out); end
  endtask

  task automatic test_stream();
    ack_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      vld_in = 1'b1;
      din    = PW'(i);
      #1;
      checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL stream_ack i=%0d got=%b exp=1", i, ack_out); end
      tick();
      checks++; if (vld_out !== 1'b1) begin failures++; $display("FAIL stream_vld i=%0d got=%b exp=1", i, vld_out); end
      checks++; if (dout !== PW'(i)) begin failures++; $display("FAIL stream_dout got=%h exp=%h", dout, PW'(i)); end
      checks++; if (count !== 5'd1) begin failures++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, count); end
    end
    vld_in = 1'b0;
    tick();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL stream_end_count got=%0d exp=0", count); end
    checks++; if (vld_out !== 1'b0) begin failures++; $display("FAIL stream_end_vld got=%b exp=0", vld_out); end
    checks++; if (xfer_cnt !== 32'd5) begin failures++; $display("FAIL stream_xfer got=%0d exp=5", xfer_cnt); end
    ack_in = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic [PW-1:0] exp;
    ack_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vld_in = 1'b1;
      din    = 32'h100 + PW'(i);
      #1;
      checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL fill_ack i=%0d got=%b exp=1", i, ack_out); end
      tick();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
    din = 32'h110;
    #1;
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL full_ack got=%b exp=0", ack_out); end
    tick();
    checks++; if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_sticky); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
    ack_in = 1'b1;
    #1;
    checks++; if (dout !== 32'h100) begin failures++; $display("FAIL full_head got=%h exp=00000100", dout); end
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL pop_only_ack got=%b exp=0", ack_out); end
    tick();
    checks++; if (count !== 5'd15) begin failures++; $display("FAIL after_pop_count got=%0d exp=15", count); end
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL freed_ack got=%b exp=1", ack_out); end
    checks++; if (dout !== 32'h101) begin failures++; $display("FAIL after_pop_dout got=%h exp=00000101", dout); end
    tick();
    vld_in = 1'b0;
    checks++; if (count !== 5'd15) begin failures++; $display("FAIL push_pop_count got=%0d exp=15", count); end
    exp = 32'h102;
    for (int n = 0; n < 40 && exp <= 32'h110; n++) begin
      #1;
      if (vld_out) begin
        checks++; if (dout !== exp) begin failures++; $display("FAIL drain_dout got=%h exp=%h", dout, exp); end
        exp = exp + 32'd1;
      end
      tick();
    end
    checks++; if (exp !== 32'h111) begin failures++; $display("FAIL drain_timeout next=%h exp=00000111", exp); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
    checks++; if (xfer_cnt !== 32'd22) begin failures++; $display("FAIL drain_xfer got=%0d exp=22", xfer_cnt); end
    ack_in = 1'b0;
  endtask

  task automatic test_full_wrap();
    int nxt;
    int exp;
    ack_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vld_in = 1'b1;
      din    = PW'(i);
      tick();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL wrap_fill_count got=%0d exp=16", count); end
    ack_in = 1'b1;
    nxt    = 16;
    exp    = 0;
    for (int c = 0; c < 60 && exp < 36; c++) begin
      vld_in = (nxt < 36);
      din    = PW'(nxt);
      #1;
      if (c == 0) begin
        checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL wrap_first_ack got=%b exp=0", ack_out); end
      end else if (c < 20) begin
        checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL wrap_ack c=%0d got=%b exp=1", c, ack_out); end
      end
      if (vld_out) begin
        checks++; if (dout !== PW'(exp)) begin failures++; $display("FAIL wrap_dout got=%0d exp=%0d", dout, exp); end
        exp++;
      end
      if (vld_in && ack_out) nxt++;
      tick();
    end
    vld_in = 1'b0;
    ack_in = 1'b0;
    checks++; if (exp !== 36) begin failures++; $display("FAIL wrap_timeout popped=%0d exp=36", exp); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", count); end
    checks++; if (xfer_cnt !== 32'd58) begin failures++; $display("FAIL wrap_xfer got=%0d exp=58", xfer_cnt); end
  endtask

  task automatic test_flush();
    ack_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vld_in = 1'b1;
      din    = 32'h200 + PW'(i);
      tick();
    end
    checks++; if (count !== 5'd7) begin failures++; $display("FAIL flush_pre_count got=%0d exp=7", count); end
    flush  = 1'b1;
    vld_in = 1'b1;
    ack_in = 1'b1;
    din    = 32'hDEAD;
    #1;
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL flush_ack got=%b exp=0", ack_out); end
    checks++; if (vld_out !== 1'b0) begin failures++; $display("FAIL flush_vld got=%b exp=0", vld_out); end
    tick();
    flush  = 1'b0;
    vld_in = 1'b0;
    ack_in = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (vld_out !== 1'b0) begin failures++; $display("FAIL flush_post_vld got=%b exp=0", vld_out); end
    checks++; if (xfer_cnt !== 32'd58) begin failures++; $display("FAIL flush_xfer got=%0d exp=58", xfer_cnt); end
    checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", ovf_sticky); end
    vld_in = 1'b1;
    din    = 32'h300;
    tick();
    vld_in = 1'b0;
    checks++; if (dout !== 32'h300) begin failures++; $display("FAIL post_flush_dout got=%h exp=00000300", dout); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL post_flush_count got=%0d exp=1", count); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++; if (xfer_cnt !== 32'd59) begin failures++; $display("FAIL post_flush_xfer got=%0d exp=59", xfer_cnt); end
  endtask

  task automatic test_async_reset();
    ack_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vld_in = 1'b1;
      din    = 32'h400 + PW'(i);
      tick();
    end
    vld_in = 1'b0;
    checks++; if (count !== 5'd9) begin failures++; $display("FAIL arst_pre_count got=%0d exp=9", count); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (vld_out !== 1'b0) begin failures++; $display("FAIL arst_vld got=%b exp=0", vld_out); end
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL arst_ack got=%b exp=0", ack_out); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
    checks++; if (xfer_cnt !== 32'd0) begin failures++; $display("FAIL arst_xfer got=%0d exp=0", xfer_cnt); end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL arst_rel_ack got=%b exp=1", ack_out); end
    vld_in = 1'b1;
    din    = 32'hA5A5A5A5;
    tick();
    din    = 32'h12345678;
    tick();
    vld_in = 1'b0;
    checks++; if (dout !== 32'hA5A5A5A5) begin failures++; $display("FAIL arst_first_dout got=%h exp=a5a5a5a5", dout); end
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL arst_count2 got=%0d exp=2", count); end
    ack_in = 1'b1;
    tick();
    checks++; if (dout !== 32'h12345678) begin failures++; $display("FAIL arst_second_dout got=%h exp=12345678", dout); end
    tick();
    ack_in = 1'b0;
    checks++; if (xfer_cnt !== 32'd2) begin failures++; $display("FAIL arst_xfer2 got=%0d exp=2", xfer_cnt); end
  endtask

  task automatic test_xfer_wrap();
    force dut.xfer_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.xfer_cnt;
    #1;
    checks++; if (xfer_cnt !== 32'hFFFF_FFFE) begin failures++; $display("FAIL xwrap_preload got=%h exp=fffffffe", xfer_cnt); end
    @(negedge clk_user);
    ack_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld_in = 1'b1;
      din    = 32'h500 + PW'(i);
      tick();
    end
    vld_in = 1'b0;
    tick();
    ack_in = 1'b0;
    checks++; if (xfer_cnt !== 32'h0000_0001) begin failures++; $display("FAIL xwrap_value got=%h exp=00000001", xfer_cnt); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL xwrap_count got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_overflow();
    test_full_wrap();
    test_flush();
    test_async_reset();
    test_xfer_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
